md_unit: RTL



---
 rtl/md_unit_pkg.sv | 37 +++
 rtl/md_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/md_unit_pkg.sv
// ============================================================================
// Module   : md_defs (package)
// Brief    : Shared MDOp encoding and default latencies for the mul/div unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package md_defs;

    localparam int MDOP_W          = 4;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [MDOP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    function automatic logic is_arith(input logic [MDOP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult(input logic [MDOP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// Module   : md_unit
// Brief    : Multi-cycle multiply/divide unit owning the HI/LO registers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module md_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic [MDOP_W-1:0] MDOp,
    input  logic [31:0]       A,
    input  logic [31:0]       B,
    output logic              Busy,
    output logic [31:0]       HI,
    output logic [31:0]       LO,
    output logic [31:0]       MDOut
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          r_phi;
    logic [31:0]          r_plo;

    logic                 w_busy;
    logic                 w_start_ok;
    logic [c_CNT_W-1:0]   w_lat;
    logic signed [63:0]   w_sa64;
    logic signed [63:0]   w_sb64;
    logic [31:0]          w_res_hi;
    logic [31:0]          w_res_lo;

    assign w_busy     = (r_cnt != '0);
    assign w_start_ok = Start && !w_busy && is_arith(MDOp);
    assign w_lat      = is_mult(MDOp) ? c_CNT_W'(MULT_CYCLES) : c_CNT_W'(DIV_CYCLES);

    // 64-bit signed operands keep the -2^31 / -1 corner well defined.
    assign w_sa64 = {{32{A[31]}}, A};
    assign w_sb64 = {{32{B[31]}}, B};

    // Divide by zero latches the current HI/LO as the pending result, so the
    // commit rewrites them unchanged (they cannot move while busy).
    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (MDOp)
            MD_MULT:  {w_res_hi, w_res_lo} = w_sa64 * w_sb64;
            MD_MULTU: {w_res_hi, w_res_lo} = {32'h0, A} * {32'h0, B};
            MD_DIV: begin
                if (B != 32'h0) begin
                    w_res_lo = 32'(w_sa64 / w_sb64);
                    w_res_hi = 32'(w_sa64 % w_sb64);
                end
            end
            MD_DIVU: begin
                if (B != 32'h0) begin
                    w_res_lo = A / B;
                    w_res_hi = A % B;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= 32'h0;
            r_lo    <= 32'h0;
            r_phi   <= 32'h0;
            r_plo   <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_phi   <= w_res_hi;
                        r_plo   <= w_res_lo;
                        r_cnt   <= w_lat;
                        r_state <= ST_RUN;
                    end
                    if (MDOp == MD_MTHI) r_hi <= A;
                    if (MDOp == MD_MTLO) r_lo <= A;
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_hi    <= r_phi;
                        r_lo    <= r_plo;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign Busy = w_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

    always_comb begin
        MDOut = 32'h0;
        if (MDOp == MD_MFHI) MDOut = r_hi;
        if (MDOp == MD_MFLO) MDOut = r_lo;
    end

endmodule

`default_nettype wire
